// File: rtl/movegen_ctrl.sv
// Sequencer and capture-first round-robin move collector for the column array.
// Grant-to-visible latency 1 cycle; grants stall while the 16-entry FIFO is full.
module movegen_ctrl #(
    parameter int NCOL       = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [255:0]         bstate,
    output logic [255:0]         board_q,
    output logic                 col_reset,
    input  logic [NCOL-1:0]      col_done,
    input  logic [NCOL-1:0]      col_valid,
    input  logic [16*NCOL-1:0]   col_move,
    output logic [NCOL-1:0]      col_ack,
    output logic [15:0]          move_data,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           move_count
);

    localparam int PW = $clog2(NCOL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [255:0]    r_board;
    logic [7:0]      r_count;
    logic [PW-1:0]   r_ptr;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic [NCOL-1:0] w_cap;
    logic [NCOL-1:0] w_cand;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_gnt;
    logic            w_found;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [15:0]     w_move;

    assign w_full = (r_cnt == CW'(FIFO_DEPTH));

    // Captures shadow quiet moves entirely; the pointer search then runs over the winners.
    always_comb begin
        w_cap   = '0;
        w_idx   = '0;
        w_gnt   = '0;
        w_found = 1'b0;
        for (int c = 0; c < NCOL; c++) begin
            w_cap[c] = col_valid[c] & col_move[16*c+15];
        end
        w_cand = (|w_cap) ? w_cap : col_valid;
        if (r_state == S_RUN && !w_full) begin
            for (int i = 0; i < NCOL; i++) begin
                w_idx = r_ptr + PW'(i);
                if (!w_found && w_cand[w_idx]) begin
                    w_found = 1'b1;
                    w_gnt   = w_idx;
                end
            end
        end
    end

    assign w_move     = col_move[16*w_gnt +: 16];
    assign w_push     = w_found;
    assign w_pop      = move_ready && (r_cnt != '0);
    assign col_ack    = w_found ? (NCOL'(1) << w_gnt) : '0;
    assign col_reset  = reset || (r_state == S_CLEAR);
    assign board_q    = r_board;
    assign move_count = r_count;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign move_valid = (r_cnt != '0);
    assign move_data  = (r_cnt != '0) ? r_mem[r_rp] : 16'h0000;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_move;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_board <= '0;
            r_count <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_board <= bstate;
                        r_count <= '0;
                        r_ptr   <= '0;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: r_state <= S_RUN;
                S_RUN: begin
                    if (w_found) begin
                        r_ptr <= w_gnt + PW'(1);
                        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                    end
                    if ((&col_done) && (col_valid == '0)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_cnt == '0) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_ctrl.sv
// Directed bench for movegen_ctrl: reset, pass timing, arbitration order, FIFO full and saturation.
module tb_movegen_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] bstate;
    logic [255:0] board_q;
    logic         col_reset;
    logic [7:0]   col_done;
    logic [7:0]   col_valid;
    logic [127:0] col_move;
    logic [7:0]   col_ack;
    logic [15:0]  move_data;
    logic         move_valid;
    logic         move_ready;
    logic         busy;
    logic         done;
    logic [7:0]   move_count;

    int nvec = 0;
    int nerr = 0;

    movegen_ctrl #(.NCOL(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .bstate(bstate), .board_q(board_q),
        .col_reset(col_reset), .col_done(col_done), .col_valid(col_valid),
        .col_move(col_move), .col_ack(col_ack), .move_data(move_data),
        .move_valid(move_valid), .move_ready(move_ready), .busy(busy), .done(done),
        .move_count(move_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_move(input int c, input logic [15:0] m);
        col_move[16*c +: 16] = m;
    endtask

    // Pulses start from IDLE; returns positioned inside the CLEAR cycle.
    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        step;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        #1;
        nvec++; if (board_q !== '0) begin nerr++; $display("FAIL rst_board_q got %h want 0", board_q); end
        nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL rst_col_ack got %h want 00", col_ack); end
        nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL rst_move_valid got %b want 0", move_valid); end
        nvec++; if (move_data !== 16'h0) begin nerr++; $display("FAIL rst_move_data got %h want 0", move_data); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
        nvec++; if (move_count !== 8'd0) begin nerr++; $display("FAIL rst_move_count got %0d want 0", move_count); end
        nvec++; if (col_reset !== 1'b1) begin nerr++; $display("FAIL rst_col_reset got %b want 1", col_reset); end
        reset = 1'b0;
        step;
        #1;
        nvec++; if (col_reset !== 1'b0) begin nerr++; $display("FAIL idle_col_reset got %b want 0", col_reset); end
    endtask

    task automatic test_min_pass;
        logic [255:0] exp_b;
        exp_b     = {8{32'h1234_5678}};
        bstate    = exp_b;
        col_done  = 8'hFF;
        col_valid = 8'h00;
        do_start;
        bstate = '0;
        #1;
        nvec++; if (col_reset !== 1'b1) begin nerr++; $display("FAIL min_c1_col_reset got %b want 1", col_reset); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL min_c1_busy got %b want 1", busy); end
        nvec++; if (board_q !== exp_b) begin nerr++; $display("FAIL min_c1_board_q got %h want %h", board_q, exp_b); end
        nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL min_c1_col_ack got %h want 00", col_ack); end
        step; #1;
        nvec++; if (col_reset !== 1'b0) begin nerr++; $display("FAIL min_c2_col_reset got %b want 0", col_reset); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL min_c2_done got %b want 0", done); end
        step; #1;
        nvec++; if (done !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL min_c3_done_busy got %b%b want 01", done, busy); end
        step; #1;
        nvec++; if (done !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL min_c4_done_busy got %b%b want 11", done, busy); end
        nvec++; if (move_count !== 8'd0) begin nerr++; $display("FAIL min_c4_move_count got %0d want 0", move_count); end
        step; #1;
        nvec++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL min_c5_done_busy got %b%b want 00", done, busy); end
        nvec++; if (board_q !== exp_b) begin nerr++; $display("FAIL min_c5_board_hold got %h want %h", board_q, exp_b); end
    endtask

    task automatic test_alternate;
        logic [7:0]  exp_ack;
        logic [15:0] exp_mv;
        bit ok;
        col_done   = 8'h00;
        col_valid  = 8'b0010_0100;
        move_ready = 1'b1;
        set_move(2, 16'h0083);
        set_move(5, 16'h0145);
        do_start;
        #1;
        nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL alt_clear_ack got %h want 00", col_ack); end
        step;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_ack = (k % 2 == 0) ? 8'h04 : 8'h20;
            nvec++; if (col_ack !== exp_ack) begin nerr++; $display("FAIL alt_ack%0d got %h want %h", k, col_ack, exp_ack); end
            if (k > 0) begin
                exp_mv = (k % 2 == 1) ? 16'h0083 : 16'h0145;
                nvec++; if (move_data !== exp_mv || move_valid !== 1'b1) begin
                    nerr++; $display("FAIL alt_data%0d got %h/%b want %h/1", k, move_data, move_valid, exp_mv);
                end
            end
            step;
        end
        col_valid = 8'h00;
        col_done  = 8'hFF;
        #1;
        nvec++; if (move_data !== 16'h0145) begin nerr++; $display("FAIL alt_data4 got %h want 0145", move_data); end
        wait_done(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL alt_done_timeout got 0 want 1"); end
        nvec++; if (move_count !== 8'd4) begin nerr++; $display("FAIL alt_move_count got %0d want 4", move_count); end
    endtask

    task automatic test_priority;
        bit ok;
        col_done   = 8'h00;
        move_ready = 1'b1;
        set_move(1, 16'h0041);
        set_move(6, 16'h8186);
        col_valid = 8'b0100_0010;
        do_start;
        step;
        #1;
        nvec++; if (col_ack !== 8'h40) begin nerr++; $display("FAIL pri_ack_a got %h want 40", col_ack); end
        step;
        col_valid = 8'b0000_0010;
        #1;
        nvec++; if (col_ack !== 8'h02) begin nerr++; $display("FAIL pri_ack_b got %h want 02", col_ack); end
        nvec++; if (move_data !== 16'h8186) begin nerr++; $display("FAIL pri_data_b got %h want 8186", move_data); end
        step;
        set_move(1, 16'h8042);
        set_move(2, 16'h0083);
        col_valid = 8'b0000_0110;
        #1;
        nvec++; if (col_ack !== 8'h02) begin nerr++; $display("FAIL pri_ack_c got %h want 02", col_ack); end
        nvec++; if (move_data !== 16'h0041) begin nerr++; $display("FAIL pri_data_c got %h want 0041", move_data); end
        step;
        col_valid = 8'b0000_0100;
        #1;
        nvec++; if (col_ack !== 8'h04) begin nerr++; $display("FAIL pri_ack_d got %h want 04", col_ack); end
        nvec++; if (move_data !== 16'h8042) begin nerr++; $display("FAIL pri_data_d got %h want 8042", move_data); end
        step;
        col_valid = 8'h00;
        col_done  = 8'hFF;
        #1;
        nvec++; if (move_data !== 16'h0083) begin nerr++; $display("FAIL pri_data_e got %h want 0083", move_data); end
        wait_done(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL pri_done_timeout got 0 want 1"); end
    endtask

    task automatic test_full;
        int acks;
        bit ok;
        col_done   = 8'h00;
        move_ready = 1'b0;
        for (int c = 0; c < 8; c++) set_move(c, 16'h0100 + 16'(c));
        col_valid = 8'hFF;
        do_start;
        step;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (col_ack != 8'h00) acks++;
            step;
        end
        #1;
        nvec++; if (acks != 16) begin nerr++; $display("FAIL full_acks got %0d want 16", acks); end
        nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL full_ack_held got %h want 00", col_ack); end
        nvec++; if (move_count !== 8'd16) begin nerr++; $display("FAIL full_count got %0d want 16", move_count); end
        nvec++; if (move_data !== 16'h0100) begin nerr++; $display("FAIL full_head got %h want 0100", move_data); end
        move_ready = 1'b1;
        #1;
        nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL full_no_passthru got %h want 00", col_ack); end
        step;
        move_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (col_ack != 8'h00) acks++;
            step;
        end
        #1;
        nvec++; if (acks != 1) begin nerr++; $display("FAIL full_after_pop got %0d want 1", acks); end
        nvec++; if (move_count !== 8'd17) begin nerr++; $display("FAIL full_count2 got %0d want 17", move_count); end
        nvec++; if (move_data !== 16'h0101) begin nerr++; $display("FAIL full_head2 got %h want 0101", move_data); end
        col_valid  = 8'h00;
        col_done   = 8'hFF;
        move_ready = 1'b1;
        wait_done(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL full_done_timeout got 0 want 1"); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_ack;
        bit ok;
        col_done   = 8'h00;
        move_ready = 1'b0;
        for (int c = 0; c < 5; c++) set_move(c, 16'h0200 + 16'(c));
        col_valid = 8'h1F;
        bstate    = {64{4'h7}};
        do_start;
        step;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_ack = 8'(1) << k;
            nvec++; if (col_ack !== exp_ack) begin nerr++; $display("FAIL rmid_ack%0d got %h want %h", k, col_ack, exp_ack); end
            step;
            col_valid[k] = 1'b0;
        end
        #1;
        nvec++; if (move_count !== 8'd5 || move_valid !== 1'b1) begin
            nerr++; $display("FAIL rmid_queued got %0d/%b want 5/1", move_count, move_valid);
        end
        reset = 1'b1;
        step;
        #1;
        nvec++; if (move_valid !== 1'b0 || move_data !== 16'h0) begin
            nerr++; $display("FAIL rmid_fifo got %b/%h want 0/0000", move_valid, move_data);
        end
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || move_count !== 8'd0) begin
            nerr++; $display("FAIL rmid_ctl got busy%b done%b cnt%0d want 0 0 0", busy, done, move_count);
        end
        nvec++; if (board_q !== '0 || col_ack !== 8'h00 || col_reset !== 1'b1) begin
            nerr++; $display("FAIL rmid_outs got ack %h col_reset %b want 00 1", col_ack, col_reset);
        end
        reset = 1'b0;
        col_done = 8'hFF;
        step;
        do_start;
        #1;
        nvec++; if (busy !== 1'b1 || col_reset !== 1'b1) begin
            nerr++; $display("FAIL rmid_restart got busy%b col_reset%b want 1 1", busy, col_reset);
        end
        wait_done(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL rmid_done_timeout got 0 want 1"); end
        nvec++; if (move_valid !== 1'b0 || move_count !== 8'd0) begin
            nerr++; $display("FAIL rmid_after got %b/%0d want 0/0", move_valid, move_count);
        end
    endtask

    function automatic logic [15:0] mk(input int c, input int k);
        logic [2:0]  cc;
        logic [11:0] kk;
        cc = 3'(c);
        kk = 12'(k);
        return {1'b0, cc, kk};
    endfunction

    task automatic test_saturate;
        int n [8];
        int rem [8];
        int g;
        int gc;
        int cyc;
        logic [15:0] q [$];
        logic [7:0]  exp_ack;
        logic [7:0]  exp_cnt;
        bit ok;
        for (int c = 0; c < 8; c++) begin
            n[c]   = 0;
            rem[c] = (c < 4) ? 38 : 37;
        end
        col_done   = 8'h00;
        move_ready = 1'b1;
        col_valid  = 8'h00;
        do_start;
        step;
        g   = 0;
        cyc = 0;
        while ((g < 300 || q.size() != 0) && cyc < 400) begin
            for (int c = 0; c < 8; c++) begin
                col_valid[c] = (rem[c] > 0);
                set_move(c, mk(c, n[c]));
            end
            if (g == 300) col_done = 8'hFF;
            #1;
            nvec++; if (move_valid !== (q.size() != 0)) begin
                nerr++; $display("FAIL sat_valid g%0d got %b want %b", g, move_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                nvec++; if (move_data !== q[0]) begin nerr++; $display("FAIL sat_data g%0d got %h want %h", g, move_data, q[0]); end
                void'(q.pop_front());
            end
            if (g == 254 || g == 255 || g == 256) begin
                exp_cnt = (g > 255) ? 8'd255 : 8'(g);
                nvec++; if (move_count !== exp_cnt) begin nerr++; $display("FAIL sat_count g%0d got %0d want %0d", g, move_count, exp_cnt); end
            end
            if (g < 300) begin
                gc      = g % 8;
                exp_ack = 8'(1) << gc;
                nvec++; if (col_ack !== exp_ack) begin nerr++; $display("FAIL sat_ack g%0d got %h want %h", g, col_ack, exp_ack); end
                q.push_back(mk(gc, n[gc]));
                n[gc]++;
                rem[gc]--;
                g++;
            end else begin
                nvec++; if (col_ack !== 8'h00) begin nerr++; $display("FAIL sat_ack_idle got %h want 00", col_ack); end
            end
            step;
            cyc++;
        end
        nvec++; if (cyc >= 400) begin nerr++; $display("FAIL sat_loop_timeout got %0d want <400", cyc); end
        col_valid = 8'h00;
        col_done  = 8'hFF;
        wait_done(ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL sat_done_timeout got 0 want 1"); end
        nvec++; if (move_count !== 8'd255) begin nerr++; $display("FAIL sat_final_count got %0d want 255", move_count); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        bstate     = '0;
        col_done   = 8'h00;
        col_valid  = 8'h00;
        col_move   = '0;
        move_ready = 1'b0;
        step;
        test_reset;
        test_min_pass;
        test_alternate;
        test_priority;
        test_full;
        test_reset_mid;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
